// File: rtl/mem_bus_pkg.sv
// Shared types and constants for simple bus-responder devices on the
// external memory interface.
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} dev_state_t;
  localparam int BUS_DATA_W = 16;
  localparam int MAX_WAIT   = 15;
endpackage

// File: rtl/sram_wait_array.sv
// Single-port synchronous RAM with registered read data (read-first).
module sram_wait_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sram_wait_device.sv
// Memory-slot stand-in: answers read/write strobes after WAIT_CYCLES wait
// states and drives the shared data bus only while returning read data.
module sram_wait_device
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  re_i,
  input  logic                  we_i,
  inout  wire  [BUS_DATA_W-1:0] data_io,
  output logic                  needWait_o
);
  dev_state_t            state;
  logic [3:0]            cnt;
  logic [ADDR_W-1:0]     lat_addr;
  logic                  lat_wr;
  logic                  req;
  logic [ADDR_W-1:0]     ram_addr;
  logic                  ram_we;
  logic                  drive;
  logic [BUS_DATA_W-1:0] rdata;

  assign req = re_i | we_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          lat_addr <= addr_i;
          lat_wr   <= we_i;
          cnt      <= 4'(WAIT_CYCLES - 1);
          state    <= (WAIT_CYCLES == 1) ? DONE : WAIT;
        end
        WAIT: begin
          if (!req) state <= IDLE;
          else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Wait is combinational in IDLE so the initiator stalls in the strobe cycle.
  always_comb begin
    needWait_o = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    needWait_o = req;
        WAIT:    needWait_o = 1'b1;
        default: needWait_o = 1'b0;
      endcase
    end
  end

  // IDLE uses the live address so a one-wait read has data ready in DONE.
  assign ram_addr = (state == IDLE) ? addr_i : lat_addr;
  assign ram_we   = rst_n && (state == DONE) && lat_wr && we_i;
  assign drive    = rst_n && (state == DONE) && !lat_wr && re_i;
  assign data_io  = drive ? rdata : 'z;

  sram_wait_array #(.ADDR_W(ADDR_W), .DATA_W(BUS_DATA_W)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_io),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_sram_wait_device.sv
// Directed bench: one device with two wait states, one with a single wait state.
module tb_sram_wait_device;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  addr1, addr2;
  logic        re1, we1, re2, we2, drv1, drv2;
  logic [15:0] dat1, dat2;
  wire  [15:0] bus1, bus2;
  logic        nw1, nw2;
  int          n_chk = 0;
  int          n_err = 0;

  localparam logic [15:0] REL = 16'hFFFF;  // pulled-up value of a released bus

  assign bus1 = drv1 ? dat1 : 'z;
  assign bus2 = drv2 ? dat2 : 'z;
  pullup pu1 (bus1);
  pullup pu2 (bus2);

  sram_wait_device #(.ADDR_W(10), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr_i(addr1), .re_i(re1), .we_i(we1),
    .data_io(bus1), .needWait_o(nw1)
  );
  sram_wait_device #(.ADDR_W(10), .WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .addr_i(addr2), .re_i(re2), .we_i(we2),
    .data_io(bus2), .needWait_o(nw2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [9:0] a, input logic [15:0] d);
    int n = 0;
    addr1 = a;
    we1   = 1'b1;
    @(negedge clk);
    while (nw1 && n < 20) begin n++; tick(); @(negedge clk); end
    chk("wr_lat", 16'(n), 16'd2);
    drv1 = 1'b1;
    dat1 = d;
    tick();
    we1  = 1'b0;
    drv1 = 1'b0;
  endtask

  task automatic rd1(input logic [9:0] a, input logic [9:0] a2,
                     input logic [15:0] exp, input string tag);
    int n = 0;
    addr1 = a;
    re1   = 1'b1;
    @(negedge clk);
    while (nw1 && n < 20) begin n++; tick(); addr1 = a2; @(negedge clk); end
    chk({tag, "_lat"}, 16'(n), 16'd2);
    chk({tag, "_data"}, bus1, exp);
    tick();
    re1 = 1'b0;
    @(negedge clk);
    chk({tag, "_rel"}, bus1, REL);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  pa [2];
    logic [15:0] pd [2];
    logic [10:0] wa;
    pa = '{10'h3FF, 10'h000};
    pd = '{16'h5A5A, 16'hC3C3};
    rst_n = 1'b0; re1 = 1'b1; we1 = 1'b0; re2 = 1'b0; we2 = 1'b0;
    drv1 = 1'b0; drv2 = 1'b0; addr1 = '0; addr2 = '0; dat1 = '0; dat2 = '0;

    // reset held with a read strobe asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_nw", 16'(nw1), 16'd0);
      chk("rst_bus", bus1, REL);
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_nw", 16'(nw1), 16'd1);
    tick();
    re1 = 1'b0;
    tick();

    wr1(10'h005, 16'hBEEF);
    rd1(10'h005, 10'h005, 16'hBEEF, "rd_beef");

    // simultaneous strobes: write wins, bus stays released by the device
    addr1 = 10'h010; re1 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("pri_nw", 16'(nw1), 16'd1);
      chk("pri_bus", bus1, REL);
      tick();
    end
    @(negedge clk);
    chk("pri_done_nw", 16'(nw1), 16'd0);
    drv1 = 1'b1; dat1 = 16'h1234;
    tick();
    re1 = 1'b0; we1 = 1'b0; drv1 = 1'b0;
    @(negedge clk);
    chk("pri_rel", bus1, REL);
    tick();
    rd1(10'h010, 10'h010, 16'h1234, "pri_rd");

    wr1(10'h020, 16'h0000);
    wr1(10'h001, 16'h1111);

    // write dropped during the wait state
    addr1 = 10'h020; we1 = 1'b1; drv1 = 1'b1; dat1 = 16'hAAAA;
    @(negedge clk);
    chk("abt_nw0", 16'(nw1), 16'd1);
    tick();
    we1 = 1'b0;
    @(negedge clk);
    chk("abt_nw1", 16'(nw1), 16'd1);
    tick();
    drv1 = 1'b0;
    rd1(10'h020, 10'h020, 16'h0000, "abt_rd");

    // reset during the wait state
    addr1 = 10'h020; we1 = 1'b1; drv1 = 1'b1; dat1 = 16'hAAAA;
    @(negedge clk);
    chk("rabt_nw0", 16'(nw1), 16'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rabt_nw1", 16'(nw1), 16'd0);
    tick();
    rst_n = 1'b1; we1 = 1'b0; drv1 = 1'b0;
    rd1(10'h020, 10'h020, 16'h0000, "rabt_rd");

    rd1(10'h001, 10'h002, 16'h1111, "amid");

    // single-wait device: preload then back-to-back reads with address wrap
    for (int i = 0; i < 2; i++) begin
      addr2 = pa[i]; we2 = 1'b1;
      @(negedge clk);
      chk("w2_nw", 16'(nw2), 16'd1);
      tick();
      drv2 = 1'b1; dat2 = pd[i];
      @(negedge clk);
      chk("w2_done_nw", 16'(nw2), 16'd0);
      tick();
      we2 = 1'b0; drv2 = 1'b0;
    end
    re2 = 1'b1; addr2 = 10'h3FF;
    @(negedge clk);
    chk("b2b_nw0", 16'(nw2), 16'd1);
    tick();
    @(negedge clk);
    chk("b2b_nw1", 16'(nw2), 16'd0);
    chk("b2b_d3ff", bus2, 16'h5A5A);
    tick();
    wa = 11'h400;
    addr2 = wa[9:0];
    @(negedge clk);
    chk("b2b_nw2", 16'(nw2), 16'd1);
    tick();
    @(negedge clk);
    chk("b2b_nw3", 16'(nw2), 16'd0);
    chk("b2b_wrap", bus2, 16'hC3C3);
    tick();
    re2 = 1'b0;
    @(negedge clk);
    chk("b2b_rel", bus2, REL);
    chk("b2b_nw4", 16'(nw2), 16'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
